debounce_multi: RTL and testbench



---
 rtl/debounce_pkg.sv | 25 ++
 rtl/debounce_multi_if.sv | 12 +
 rtl/debounce_ch.sv | 148 ++++++++++++++
 rtl/debounce_multi.sv | 41 ++++
 tb/tb_debounce_multi.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/debounce_pkg.sv
// Shared state encoding and counter sizing for the multi-channel button debouncer.
// Compile with +define+DEBOUNCE_REPEAT_EN to enable hold-to-repeat press pulses.
package debounce_pkg;

  // Bit 3 of the state is the debounced level; bit 2 marks the one-cycle accept state.
  localparam logic [3:0] INI  = 4'b0000;
  localparam logic [3:0] WQ   = 4'b0001;
  localparam logic [3:0] SCEN = 4'b1100;
  localparam logic [3:0] CCR  = 4'b1000;
  localparam logic [3:0] WFCR = 4'b1001;

  localparam int unsigned CLEAN_BIT = 3;
  localparam int unsigned PULSE_BIT = 2;

  function automatic int unsigned cnt_width(input int unsigned a,
                                            input int unsigned b,
                                            input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/debounce_multi_if.sv
// Button bundle: raw levels in, debounced level and press/release pulses out.
interface debounce_multi_if #(
  parameter int unsigned W = 1
);
  logic [W-1:0] btn_raw;
  logic [W-1:0] clean;
  logic [W-1:0] single;
  logic [W-1:0] release_p;

  modport master (output btn_raw, input clean, input single, input release_p);
  modport slave  (input btn_raw, output clean, output single, output release_p);
endinterface

// File: rtl/debounce_ch.sv
// One debounced button: 2-flop synchroniser, settle FSM, counter, optional repeat flag.
// Repeat pulses are built only when DEBOUNCE_REPEAT_EN is defined.
module debounce_ch
  import debounce_pkg::*;
#(
  parameter int unsigned DB_CYCLES  = 1_000_000,
  parameter int unsigned REP_DELAY  = 25_000_000,
  parameter int unsigned REP_PERIOD = 5_000_000
) (
  input logic             clk,
  input logic             rst_n,
  debounce_multi_if.slave bus
);

  localparam int unsigned      CNT_W   = cnt_width(DB_CYCLES, REP_DELAY, REP_PERIOD);
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CYCLES - 1);

  logic             s1_q, s2_q;
  logic [3:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             release_q, release_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= bus.btn_raw[0];
      s2_q <= s1_q;
    end
  end

`ifdef DEBOUNCE_REPEAT_EN
  localparam logic [CNT_W-1:0] REP_DLY_LAST = CNT_W'(REP_DELAY - 1);
  localparam logic [CNT_W-1:0] REP_PER_LAST = CNT_W'(REP_PERIOD - 1);

  logic rep_q, rep_d;
  logic rep_pulse_q, rep_pulse_d;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
`ifdef DEBOUNCE_REPEAT_EN
    rep_d   = rep_q;
`endif
    case (state_q)
      INI: begin
        cnt_d = '0;
        if (s2_q) state_d = WQ;
      end
      WQ: begin
        if (!s2_q) begin
          state_d = INI;
          cnt_d   = '0;
        end else if (cnt_q == DB_LAST) begin
          state_d = SCEN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      SCEN: begin
        state_d = CCR;
        cnt_d   = '0;
      end
      CCR: begin
        if (!s2_q) begin
          state_d = WFCR;
          cnt_d   = '0;
`ifdef DEBOUNCE_REPEAT_EN
          rep_d   = 1'b0;
`endif
        end else begin
`ifdef DEBOUNCE_REPEAT_EN
          if (cnt_q == (rep_q ? REP_PER_LAST : REP_DLY_LAST)) begin
            cnt_d = '0;
            rep_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
`else
          cnt_d = '0;
`endif
        end
      end
      WFCR: begin
        if (s2_q) begin
          state_d = CCR;
          cnt_d   = '0;
        end else if (cnt_q == DB_LAST) begin
          state_d = INI;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = INI;
        cnt_d   = '0;
      end
    endcase
  end

  // Pulses are registered from next-state values so they line up with the state
  // they describe; s1_q is the s2 level the channel will see in that cycle.
  always_comb begin
    release_d = (state_d == WFCR) && (cnt_d == DB_LAST) && !s1_q;
  end

`ifdef DEBOUNCE_REPEAT_EN
  always_comb begin
    rep_pulse_d = (state_d == CCR) &&
                  (cnt_d == (rep_d ? REP_PER_LAST : REP_DLY_LAST));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rep_q       <= 1'b0;
      rep_pulse_q <= 1'b0;
    end else begin
      rep_q       <= rep_d;
      rep_pulse_q <= rep_pulse_d;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= INI;
      cnt_q     <= '0;
      release_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      release_q <= release_d;
    end
  end

  assign bus.clean     = state_q[CLEAN_BIT];
  assign bus.release_p = release_q;
`ifdef DEBOUNCE_REPEAT_EN
  assign bus.single    = state_q[PULSE_BIT] | rep_pulse_q;
`else
  assign bus.single    = state_q[PULSE_BIT];
`endif

endmodule

// File: rtl/debounce_multi.sv
// N-channel pushbutton debouncer: independent channels plus an any-pressed flag.
// Optional hold-to-repeat pulses are enabled by defining DEBOUNCE_REPEAT_EN.
module debounce_multi
  import debounce_pkg::*;
#(
  parameter int unsigned N_CH       = 5,
  parameter int unsigned DB_CYCLES  = 1_000_000,
  parameter int unsigned REP_DELAY  = 25_000_000,
  parameter int unsigned REP_PERIOD = 5_000_000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] btn_raw,
  output logic [N_CH-1:0] clean,
  output logic [N_CH-1:0] single,
  output logic [N_CH-1:0] release_p,
  output logic            any_pressed
);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    debounce_multi_if #(.W(1)) ch_if ();

    assign ch_if.btn_raw = btn_raw[i];
    assign clean[i]      = ch_if.clean;
    assign single[i]     = ch_if.single;
    assign release_p[i]  = ch_if.release_p;

    debounce_ch #(
      .DB_CYCLES (DB_CYCLES),
      .REP_DELAY (REP_DELAY),
      .REP_PERIOD(REP_PERIOD)
    ) u_ch (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (ch_if.slave)
    );
  end

  assign any_pressed = |clean;

endmodule

// File: tb/tb_debounce_multi.sv
// Directed bench for debounce_multi (3 channels, DB=4, REP_DELAY=10, REP_PERIOD=3).
// Cycle c is the interval after rising edge c; inputs change at the falling edge before it.
module tb_debounce_multi;

  localparam int unsigned NCH = 3;
  localparam int unsigned DB  = 4;
  localparam int unsigned RD  = 10;
  localparam int unsigned RP  = 3;
`ifdef DEBOUNCE_REPEAT_EN
  localparam bit REP_ON = 1'b1;
`else
  localparam bit REP_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic any_pressed;
  int   n_checks = 0;
  int   n_fail = 0;

  debounce_multi_if #(.W(NCH)) bus ();

  debounce_multi #(
    .N_CH      (NCH),
    .DB_CYCLES (DB),
    .REP_DELAY (RD),
    .REP_PERIOD(RP)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn_raw    (bus.btn_raw),
    .clean      (bus.clean),
    .single     (bus.single),
    .release_p  (bus.release_p),
    .any_pressed(any_pressed)
  );

  always #5 clk = ~clk;

  task automatic next_cycle;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Repeat pulses expected at first, first+RP, ... up to last (repeat build only).
  function automatic bit rep_hit(input int c, input int first, input int last);
    int rp;
    rp = int'(RP);
    return REP_ON && (c >= first) && (c <= last) && (((c - first) % rp) == 0);
  endfunction

  task automatic test_reset;
    bus.btn_raw = '0;
    rst_n = 1'b0;
    repeat (3) next_cycle();
    n_checks++; if (bus.clean !== 3'b000) begin n_fail++; $display("FAIL reset.clean got=%b exp=000", bus.clean); end
    n_checks++; if (bus.single !== 3'b000) begin n_fail++; $display("FAIL reset.single got=%b exp=000", bus.single); end
    n_checks++; if (bus.release_p !== 3'b000) begin n_fail++; $display("FAIL reset.release_p got=%b exp=000", bus.release_p); end
    n_checks++; if (any_pressed !== 1'b0) begin n_fail++; $display("FAIL reset.any got=%b exp=0", any_pressed); end
    rst_n = 1'b1;
    repeat (3) next_cycle();
    n_checks++; if ({bus.clean, bus.single, bus.release_p} !== 9'd0) begin n_fail++; $display("FAIL reset_exit.outputs got=%b exp=0", {bus.clean, bus.single, bus.release_p}); end
  endtask

  task automatic test_clean_press;
    logic es, ec, er;
    bus.btn_raw = 3'b001;
    for (int c = 0; c <= 30; c++) begin
      next_cycle();
      es = (c == 6) || rep_hit(c, 16, 22);
      ec = (c >= 6) && (c <= 26);
      er = (c == 26);
      n_checks++; if (bus.single !== {2'b00, es}) begin n_fail++; $display("FAIL clean_press.single c=%0d got=%b exp=%b", c, bus.single, {2'b00, es}); end
      n_checks++; if (bus.clean !== {2'b00, ec}) begin n_fail++; $display("FAIL clean_press.clean c=%0d got=%b exp=%b", c, bus.clean, {2'b00, ec}); end
      n_checks++; if (bus.release_p !== {2'b00, er}) begin n_fail++; $display("FAIL clean_press.release_p c=%0d got=%b exp=%b", c, bus.release_p, {2'b00, er}); end
      n_checks++; if (any_pressed !== ec) begin n_fail++; $display("FAIL clean_press.any c=%0d got=%b exp=%b", c, any_pressed, ec); end
      if (c == 20) bus.btn_raw = 3'b000;
    end
  endtask

  task automatic test_press_bounce;
    logic [5:0] pat;
    logic       b;
    pat = 6'b011011;
    for (int c = 0; c <= 23; c++) begin
      b = (c < 12) ? pat[c / 2] : 1'b0;
      bus.btn_raw = {1'b0, b, 1'b0};
      next_cycle();
      n_checks++; if (bus.clean !== 3'b000) begin n_fail++; $display("FAIL press_bounce.clean c=%0d got=%b exp=000", c, bus.clean); end
      n_checks++; if (bus.single !== 3'b000) begin n_fail++; $display("FAIL press_bounce.single c=%0d got=%b exp=000", c, bus.single); end
    end
    bus.btn_raw = '0;
  endtask

  task automatic test_release_bounce;
    logic es, ec;
    bus.btn_raw = 3'b100;
    for (int c = 0; c <= 24; c++) begin
      next_cycle();
      es = (c == 6) || rep_hit(c, 23, 24);
      ec = (c >= 6);
      n_checks++; if (bus.clean !== {ec, 2'b00}) begin n_fail++; $display("FAIL release_bounce.clean c=%0d got=%b exp=%b", c, bus.clean, {ec, 2'b00}); end
      n_checks++; if (bus.single !== {es, 2'b00}) begin n_fail++; $display("FAIL release_bounce.single c=%0d got=%b exp=%b", c, bus.single, {es, 2'b00}); end
      n_checks++; if (bus.release_p !== 3'b000) begin n_fail++; $display("FAIL release_bounce.release_p c=%0d got=%b exp=000", c, bus.release_p); end
      if (c == 9)  bus.btn_raw = 3'b000;
      if (c == 11) bus.btn_raw = 3'b100;
    end
    bus.btn_raw = '0;
    repeat (15) next_cycle();
    n_checks++; if (bus.clean !== 3'b000) begin n_fail++; $display("FAIL release_bounce.settle got=%b exp=000", bus.clean); end
  endtask

  task automatic test_simultaneous;
    logic [2:0] es, ec;
    bus.btn_raw = 3'b111;
    for (int c = 0; c <= 8; c++) begin
      next_cycle();
      es = (c == 6) ? 3'b111 : 3'b000;
      ec = (c >= 6) ? 3'b111 : 3'b000;
      n_checks++; if (bus.single !== es) begin n_fail++; $display("FAIL simultaneous.single c=%0d got=%b exp=%b", c, bus.single, es); end
      n_checks++; if (bus.clean !== ec) begin n_fail++; $display("FAIL simultaneous.clean c=%0d got=%b exp=%b", c, bus.clean, ec); end
      n_checks++; if (any_pressed !== (c >= 6)) begin n_fail++; $display("FAIL simultaneous.any c=%0d got=%b exp=%b", c, any_pressed, (c >= 6)); end
    end
    bus.btn_raw = '0;
    repeat (14) next_cycle();
    n_checks++; if (bus.clean !== 3'b000) begin n_fail++; $display("FAIL simultaneous.idle_clean got=%b exp=000", bus.clean); end
    n_checks++; if (any_pressed !== 1'b0) begin n_fail++; $display("FAIL simultaneous.idle_any got=%b exp=0", any_pressed); end
  endtask

  task automatic test_reset_midop;
    logic [2:0] es, ec;
    bus.btn_raw = 3'b111;
    repeat (4) next_cycle();
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if ({bus.clean, bus.single, bus.release_p, any_pressed} !== 10'd0) begin n_fail++; $display("FAIL reset_wq.outputs got=%b exp=0", {bus.clean, bus.single, bus.release_p, any_pressed}); end
    for (int pass = 0; pass < 2; pass++) begin
      next_cycle();
      rst_n = 1'b1;
      for (int c = 0; c <= 8; c++) begin
        next_cycle();
        es = (c == 6) ? 3'b111 : 3'b000;
        ec = (c >= 6) ? 3'b111 : 3'b000;
        n_checks++; if (bus.single !== es) begin n_fail++; $display("FAIL reset_restart.single pass=%0d c=%0d got=%b exp=%b", pass, c, bus.single, es); end
        n_checks++; if (bus.clean !== ec) begin n_fail++; $display("FAIL reset_restart.clean pass=%0d c=%0d got=%b exp=%b", pass, c, bus.clean, ec); end
      end
      #2 rst_n = 1'b0;
      #1;
      n_checks++; if (bus.clean !== 3'b000) begin n_fail++; $display("FAIL reset_ccr.clean pass=%0d got=%b exp=000", pass, bus.clean); end
      n_checks++; if (any_pressed !== 1'b0) begin n_fail++; $display("FAIL reset_ccr.any pass=%0d got=%b exp=0", pass, any_pressed); end
      n_checks++; if ({bus.single, bus.release_p} !== 6'd0) begin n_fail++; $display("FAIL reset_ccr.pulses pass=%0d got=%b exp=0", pass, {bus.single, bus.release_p}); end
    end
    bus.btn_raw = '0;
    next_cycle();
    rst_n = 1'b1;
    repeat (5) next_cycle();
  endtask

  task automatic test_repeat;
    logic es, ec, er;
    bus.btn_raw = 3'b001;
    for (int c = 0; c <= 47; c++) begin
      next_cycle();
      es = (c == 6) || rep_hit(c, 16, 40);
      ec = (c >= 6) && (c <= 45);
      er = (c == 45);
      n_checks++; if (bus.single !== {2'b00, es}) begin n_fail++; $display("FAIL repeat.single c=%0d got=%b exp=%b", c, bus.single, {2'b00, es}); end
      n_checks++; if (bus.clean !== {2'b00, ec}) begin n_fail++; $display("FAIL repeat.clean c=%0d got=%b exp=%b", c, bus.clean, {2'b00, ec}); end
      n_checks++; if (bus.release_p !== {2'b00, er}) begin n_fail++; $display("FAIL repeat.release_p c=%0d got=%b exp=%b", c, bus.release_p, {2'b00, er}); end
      if (c == 39) bus.btn_raw = 3'b000;
    end
  endtask

  initial begin
    bus.btn_raw = '0;
    test_reset();
    test_clean_press();
    test_press_bounce();
    test_release_bounce();
    test_simultaneous();
    test_reset_midop();
    test_repeat();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached checks=%0d", n_checks);
    $fatal(1);
  end

endmodule
